ysyx_24100005_imem_responder: RTL and testbench

// - Instruction-memory responder: serves fetch requests carrying a PC and returns the 32-bit instruction word.
// - Sits between the core's fetch stage (the initiator) and a word-addressed instruction store.
// - Handshaked request/response channels with a configurable access latency and one outstanding request.
// - Flags misaligned or out-of-range fetches instead of returning garbage.

---
 rtl/ysyx_24100005_pkg.sv | 30 +++
 rtl/ysyx_24100005_imem_array.sv | 33 +++
 rtl/ysyx_24100005_imem_responder.sv | 117 +++++++++++
 tb/tb_ysyx_24100005_imem_responder.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_24100005_pkg.sv
// Shared core definitions: reset PC, canonical NOP, fetch FSM states and the
// instruction-fetch response payload.
package ysyx_24100005_pkg;

  localparam logic [31:0] RESET_PC  = 32'h8000_0000;
  localparam logic [31:0] NOP_INST  = 32'h0000_0013;
  localparam int unsigned XLEN      = 32;
  localparam int unsigned LAT_CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } fsm_state_e;

  typedef struct packed {
    logic            err;
    logic [XLEN-1:0] inst;
  } imem_rsp_t;

  // Misaligned PC, or word index past the end; addresses below base wrap high.
  function automatic logic fetch_err(input logic [XLEN-1:0] addr,
                                     input logic [XLEN-1:0] base,
                                     input logic [XLEN-1:0] depth);
    logic [XLEN-1:0] off;
    off = addr - base;
    return (addr[1:0] != 2'b00) || ((off >> 2) >= depth);
  endfunction

endpackage

// File: rtl/ysyx_24100005_imem_array.sv
// Word-addressed instruction store: one write port, one synchronous read port
// whose output register only updates when a read is enabled.
module ysyx_24100005_imem_array
  import ysyx_24100005_pkg::*;
#(
  parameter int unsigned DEPTH = 4096,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            i_we,
  input  logic [AW-1:0]   i_waddr,
  input  logic [XLEN-1:0] i_wdata,
  input  logic            i_re,
  input  logic [AW-1:0]   i_raddr,
  output logic [XLEN-1:0] o_rdata
);

  logic [XLEN-1:0] r_mem [DEPTH];
  logic [XLEN-1:0] r_rdata;

  // Read sees the pre-write contents when both ports hit the same word.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
    if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/ysyx_24100005_imem_responder.sv
// Instruction-memory responder: accepts one fetch at a time, returns the word
// (or ERR_INST with rsp_err) LATENCY cycles after acceptance.
module ysyx_24100005_imem_responder
  import ysyx_24100005_pkg::*;
#(
  parameter logic [XLEN-1:0] BASE_ADDR = RESET_PC,
  parameter int unsigned     DEPTH     = 4096,
  parameter int unsigned     LATENCY   = 1,
  parameter logic [XLEN-1:0] ERR_INST  = NOP_INST,
  localparam int unsigned    AW        = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [XLEN-1:0] req_addr,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [XLEN-1:0] rsp_inst,
  output logic            rsp_err,
  input  logic            ld_en,
  input  logic [AW-1:0]   ld_addr,
  input  logic [XLEN-1:0] ld_data
);

  localparam logic [LAT_CNT_W-1:0] LAT_M1 = LAT_CNT_W'(LATENCY - 1);

  fsm_state_e           r_state;
  logic [LAT_CNT_W-1:0] r_cnt;
  logic                 r_req_ready;
  logic                 r_rsp_valid;
  logic                 r_err;
  imem_rsp_t            r_rsp;

  logic [XLEN-1:0]      w_off;
  logic [AW-1:0]        w_idx;
  logic                 w_err;
  logic                 w_accept;
  logic                 w_ld_we;
  logic                 w_rd_en;
  logic [XLEN-1:0]      w_rdata;

  // Address decode on the live request; only the latched result is used later.
  assign w_off    = req_addr - BASE_ADDR;
  assign w_idx    = AW'(w_off >> 2);
  assign w_err    = fetch_err(req_addr, BASE_ADDR, XLEN'(DEPTH));
  assign w_accept = r_req_ready && req_valid;
  assign w_ld_we  = ld_en && (r_state == IDLE);
  assign w_rd_en  = w_accept && !w_err;

  // The RAM output register doubles as the fetched-word holding register.
  ysyx_24100005_imem_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .clk     (clk),
    .i_we    (w_ld_we),
    .i_waddr (ld_addr),
    .i_wdata (ld_data),
    .i_re    (w_rd_en),
    .i_raddr (w_idx),
    .o_rdata (w_rdata)
  );

  // WAIT always spans at least the one-cycle RAM read, so the response
  // registers are loaded exactly LATENCY edges after acceptance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_req_ready <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_err       <= 1'b0;
      r_rsp       <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_req_ready <= 1'b1;
          if (w_accept) begin
            r_err       <= w_err;
            r_cnt       <= LAT_M1;
            r_req_ready <= 1'b0;
            r_state     <= WAIT;
          end
        end
        WAIT: begin
          if (r_cnt == '0) begin
            r_rsp_valid <= 1'b1;
            r_rsp.err   <= r_err;
            r_rsp.inst  <= r_err ? ERR_INST : w_rdata;
            r_state     <= RESP;
          end else begin
            r_cnt <= r_cnt - LAT_CNT_W'(1);
          end
        end
        RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_req_ready <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_rsp_valid <= 1'b0;
          r_req_ready <= 1'b0;
          r_state     <= IDLE;
        end
      endcase
    end
  end

  assign req_ready = r_req_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_inst  = r_rsp.inst;
  assign rsp_err   = r_rsp.err;

endmodule

// File: tb/tb_ysyx_24100005_imem_responder.sv
// Bench for the instruction-memory responder: a LATENCY=1 and a LATENCY=3
// instance, directed table, hand-written corner sequences and random fetches.
module tb_ysyx_24100005_imem_responder;

  localparam logic [31:0] BASE = 32'h8000_0000;
  localparam int unsigned NW   = 4096;

  logic        clk;
  logic        rst       [2];
  logic        req_valid [2];
  logic        req_ready [2];
  logic [31:0] req_addr  [2];
  logic        rsp_valid [2];
  logic        rsp_ready [2];
  logic [31:0] rsp_inst  [2];
  logic        rsp_err   [2];
  logic        ld_en     [2];
  logic [11:0] ld_addr   [2];
  logic [31:0] ld_data   [2];

  logic [31:0] mem_m [2][NW];
  int n_cmp = 0;
  int n_bad = 0;

  ysyx_24100005_imem_responder #(.LATENCY(1)) u_dut_l1 (
    .clk(clk), .rst(rst[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_addr(req_addr[0]), .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
    .rsp_inst(rsp_inst[0]), .rsp_err(rsp_err[0]), .ld_en(ld_en[0]),
    .ld_addr(ld_addr[0]), .ld_data(ld_data[0])
  );

  ysyx_24100005_imem_responder #(.LATENCY(3)) u_dut_l3 (
    .clk(clk), .rst(rst[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_addr(req_addr[1]), .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
    .rsp_inst(rsp_inst[1]), .rsp_err(rsp_err[1]), .ld_en(ld_en[1]),
    .ld_addr(ld_addr[1]), .ld_data(ld_data[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int lat(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  // Reference: plain 64-bit range arithmetic, no wrap tricks.
  function automatic void model_rsp(input int d, input logic [31:0] a,
                                    output bit e, output logic [31:0] inst);
    longint unsigned la;
    la = 64'(a);
    if ((la % 4) != 0 || la < 64'(BASE) || (la - 64'(BASE)) / 4 >= 64'(NW)) begin
      e = 1'b1;
      inst = 32'h0000_0013;
    end else begin
      e = 1'b0;
      inst = mem_m[d][(la - 64'(BASE)) / 4];
    end
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input int d, input logic [11:0] a, input logic [31:0] v);
    ld_en[d] = 1'b1;
    ld_addr[d] = a;
    ld_data[d] = v;
    tick();
    ld_en[d] = 1'b0;
    mem_m[d][a] = v;
  endtask

  task automatic fetch(input int d, input logic [31:0] addr, input int hold,
                       input bit do_ld, input logic [11:0] la, input logic [31:0] lv,
                       input bit exp_err, input logic [31:0] exp_inst, input string nm);
    int k;
    k = 0;
    while (req_ready[d] !== 1'b1 && k < 20) begin
      tick();
      k++;
    end
    chk({nm, ":req_ready_idle"}, 32'(req_ready[d]), 32'd1);
    if (req_ready[d] !== 1'b1) return;
    req_valid[d] = 1'b1;
    req_addr[d]  = addr;
    if (do_ld) begin
      ld_en[d] = 1'b1;
      ld_addr[d] = la;
      ld_data[d] = lv;
    end
    tick();
    req_valid[d] = 1'b0;
    req_addr[d]  = $urandom;
    ld_en[d]     = 1'b0;
    if (do_ld) mem_m[d][la] = lv;
    k = 0;
    while (rsp_valid[d] !== 1'b1 && k < 40) begin
      chk({nm, ":req_ready_busy"}, 32'(req_ready[d]), 32'd0);
      rsp_ready[d] = 1'($urandom % 2);
      tick();
      k++;
    end
    chk({nm, ":latency"}, 32'(k), 32'(lat(d)));
    if (rsp_valid[d] !== 1'b1) return;
    for (int h = 0; h <= hold; h++) begin
      chk({nm, ":rsp_valid"}, 32'(rsp_valid[d]), 32'd1);
      chk({nm, ":rsp_inst"}, rsp_inst[d], exp_inst);
      chk({nm, ":rsp_err"}, 32'(rsp_err[d]), 32'(exp_err));
      chk({nm, ":req_ready_resp"}, 32'(req_ready[d]), 32'd0);
      rsp_ready[d] = (h == hold);
      tick();
    end
    chk({nm, ":rsp_valid_drop"}, 32'(rsp_valid[d]), 32'd0);
    chk({nm, ":req_ready_after"}, 32'(req_ready[d]), 32'd1);
    chk({nm, ":rsp_inst_hold"}, rsp_inst[d], exp_inst);
    rsp_ready[d] = 1'($urandom % 2);
  endtask

  typedef struct {
    logic [31:0] addr;
    int          hold;
    bit          err;
    logic [31:0] inst;
  } vec_t;

  vec_t vecs [8];

  initial begin : main
    bit          e;
    logic [31:0] ei;
    logic [31:0] a;
    logic [31:0] r;
    int          kind;
    int          w;

    vecs[0] = '{32'h8000_0000, 0, 1'b0, 32'h0000_0297};
    vecs[1] = '{32'h8000_0004, 5, 1'b0, 32'h0102_0313};
    vecs[2] = '{32'h8000_0002, 0, 1'b1, 32'h0000_0013};
    vecs[3] = '{32'h8000_4000, 1, 1'b1, 32'h0000_0013};
    vecs[4] = '{32'h7FFF_FFFC, 0, 1'b1, 32'h0000_0013};
    vecs[5] = '{32'h8000_3FFC, 2, 1'b0, 32'h1234_5678};
    vecs[6] = '{32'h8000_0008, 3, 1'b0, 32'hCAFE_0001};
    vecs[7] = '{32'h0000_0000, 0, 1'b1, 32'h0000_0013};

    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; req_valid[d] = 1'b0; req_addr[d] = '0; rsp_ready[d] = 1'b0;
      ld_en[d] = 1'b0; ld_addr[d] = '0; ld_data[d] = '0;
    end
    repeat (3) tick();
    for (int d = 0; d < 2; d++) begin
      chk("reset:req_ready", 32'(req_ready[d]), 32'd0);
      chk("reset:rsp_valid", 32'(rsp_valid[d]), 32'd0);
      chk("reset:rsp_inst", rsp_inst[d], 32'd0);
      chk("reset:rsp_err", 32'(rsp_err[d]), 32'd0);
      rst[d] = 1'b0;
    end

    for (int d = 0; d < 2; d++) begin
      preload(d, 12'd0, 32'h0000_0297);
      preload(d, 12'd1, 32'h0102_0313);
      preload(d, 12'd2, 32'hCAFE_0001);
      preload(d, 12'd5, 32'h1111_1111);
      preload(d, 12'd4095, 32'h1234_5678);
    end

    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 8; i++)
        fetch(d, vecs[i].addr, vecs[i].hold, 1'b0, 12'd0, 32'd0,
              vecs[i].err, vecs[i].inst, $sformatf("vec%0d_d%0d", i, d));

    // Reset while the LATENCY=3 instance is in WAIT.
    req_valid[1] = 1'b1;
    req_addr[1] = 32'h8000_0000;
    tick();
    req_valid[1] = 1'b0;
    tick();
    rst[1] = 1'b1;
    #1;
    chk("midrst:rsp_valid", 32'(rsp_valid[1]), 32'd0);
    chk("midrst:req_ready", 32'(req_ready[1]), 32'd0);
    chk("midrst:rsp_inst", rsp_inst[1], 32'd0);
    tick();
    tick();
    rst[1] = 1'b0;
    rsp_ready[1] = 1'b1;
    for (int i = 0; i < 6; i++) begin
      chk("midrst:no_rsp", 32'(rsp_valid[1]), 32'd0);
      tick();
    end
    fetch(1, 32'h8000_0008, 0, 1'b0, 12'd0, 32'd0, 1'b0, mem_m[1][2], "midrst_after");

    // Preload strobes during WAIT/RESP must not land.
    req_valid[1] = 1'b1;
    req_addr[1] = 32'h8000_0000;
    tick();
    req_valid[1] = 1'b0;
    ld_en[1] = 1'b1;
    ld_addr[1] = 12'd2;
    ld_data[1] = 32'hDEAD_BEEF;
    for (int i = 0; i < 10 && rsp_valid[1] !== 1'b1; i++) tick();
    chk("ldwait:rsp_valid", 32'(rsp_valid[1]), 32'd1);
    chk("ldwait:rsp_inst", rsp_inst[1], mem_m[1][0]);
    rsp_ready[1] = 1'b1;
    tick();
    ld_en[1] = 1'b0;
    fetch(1, 32'h8000_0008, 1, 1'b0, 12'd0, 32'd0, 1'b0, 32'hCAFE_0001, "ldwait_after");

    // Same-edge preload and fetch of one word returns the old word.
    fetch(0, 32'h8000_0014, 0, 1'b1, 12'd5, 32'h2222_2222, 1'b0, 32'h1111_1111, "rbw_old");
    fetch(0, 32'h8000_0014, 0, 1'b0, 12'd0, 32'd0, 1'b0, 32'h2222_2222, "rbw_new");

    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 16; i++) preload(d, 12'(i), $urandom);
      preload(d, 12'd4095, $urandom);
      for (int n = 0; n < 120; n++) begin
        kind = int'($urandom % 6);
        w = int'($urandom % 17);
        if (w == 16) w = 4095;
        case (kind)
          3:       a = BASE + 32'(w * 4) + 32'($urandom_range(1, 3));
          4:       a = 32'h8000_4000 + 32'(($urandom % 100000) * 4);
          5:       begin r = $urandom; a = r & 32'h7FFF_FFFC; end
          default: a = BASE + 32'(w * 4);
        endcase
        model_rsp(d, a, e, ei);
        fetch(d, a, int'($urandom % 4), ($urandom % 4) == 0, 12'($urandom % 16),
              $urandom, e, ei, $sformatf("rnd%0d_d%0d", n, d));
        repeat ($urandom % 3) tick();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
